// File: rtl/fft_uart_sched.sv
// fft_uart_sched: captures one FFT frame into a FIFO on host request and streams it word by word to a UART
module fft_uart_sched #(
   parameter int FRAME_LEN = 1024,
   parameter int IDX_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_ready,
   output logic             tx_ready,
   input  logic             s_valid,
   input  logic [IDX_W-1:0] s_index,
   input  logic             fifo_full,
   input  logic             fifo_empty,
   output logic             fifo_wr_en,
   output logic             fifo_rd_en,
   output logic             uart_start,
   input  logic             uart_done,
   output logic             frame_done,
   output logic             overflow,
   output logic             seq_err
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ARM     = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] HANDOFF = 3'd3;
   localparam logic [2:0] SEND    = 3'd4;
   localparam logic [2:0] WAIT_TX = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;
   localparam logic [IDX_W:0] LEN = (IDX_W+1)'(FRAME_LEN);

   logic [2:0]     state_q, state_d;
   logic           rx_s1_q, rx_s2_q, rx_prev_q, rx_rise;
   logic [IDX_W:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, wr_inc;
   logic           tx_ready_q, tx_ready_d, start_q;
   logic           overflow_q, overflow_d, seq_err_q, seq_err_d;

   assign rx_rise    = rx_s2_q & ~rx_prev_q;
   assign wr_inc     = wr_cnt_q + 1'b1;
   assign tx_ready_d = (state_d == IDLE) | (tx_ready_q & (state_d != HANDOFF));
   assign tx_ready   = tx_ready_q;
   assign uart_start = start_q;
   assign frame_done = state_q == DONE;
   assign overflow   = overflow_q;
   assign seq_err    = seq_err_q;

   // two-flop synchronizer plus one history flop for rising-edge detection of the host request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q   <= 1'b0;
         rx_s2_q   <= 1'b0;
         rx_prev_q <= 1'b0;
      end else begin
         rx_s1_q   <= rx_ready;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   // sequencing: next state, counters, sticky errors and the combinational FIFO strobes
   always_comb begin
      state_d    = state_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      overflow_d = overflow_q;
      seq_err_d  = seq_err_q;
      fifo_wr_en = 1'b0;
      fifo_rd_en = 1'b0;
      case (state_q)
         IDLE: if (rx_rise) begin
            state_d    = ARM;
            wr_cnt_d   = '0;
            rd_cnt_d   = '0;
            overflow_d = 1'b0;
            seq_err_d  = 1'b0;
         end
         ARM: if (!rx_s2_q) state_d = IDLE;
            else if (s_valid && s_index == '0) begin
               fifo_wr_en = 1'b1;
               wr_cnt_d   = wr_inc;
               state_d    = (wr_inc == LEN) ? HANDOFF : CAPTURE;
            end
         CAPTURE: if (s_valid) begin
            fifo_wr_en = ~fifo_full;
            wr_cnt_d   = wr_inc;
            overflow_d = overflow_q | fifo_full;
            seq_err_d  = seq_err_q | ({1'b0, s_index} != wr_cnt_q);
            if (wr_inc == LEN) state_d = HANDOFF;
         end
         HANDOFF: state_d = SEND;
         SEND: if (!fifo_empty && rd_cnt_q < LEN) begin
            fifo_rd_en = 1'b1;
            rd_cnt_d   = rd_cnt_q + 1'b1;
            state_d    = WAIT_TX;
         end
         WAIT_TX: if (uart_done) state_d = (rd_cnt_q < LEN) ? SEND : DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state registers; uart_start follows the read strobe by one cycle so the FIFO data is valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         tx_ready_q <= 1'b1;
         start_q    <= 1'b0;
         overflow_q <= 1'b0;
         seq_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         tx_ready_q <= tx_ready_d;
         start_q    <= fifo_rd_en;
         overflow_q <= overflow_d;
         seq_err_q  <= seq_err_d;
      end
   end
endmodule

// File: tb/tb_fft_uart_sched.sv
// tb_fft_uart_sched: directed frame capture and send scenarios with hand-computed expectations
module tb_fft_uart_sched;
   localparam int FL = 8;
   localparam int IW = 16;

   logic clk = 1'b0, rst_n = 1'b0, rx_ready = 1'b0, s_valid = 1'b0;
   logic fifo_full = 1'b0, fifo_empty = 1'b0, uart_done_r = 1'b0, uart_stray = 1'b0, uart_en = 1'b1;
   logic [IW-1:0] s_index = '0;
   logic tx_ready, fifo_wr_en, fifo_rd_en, uart_start, uart_done, frame_done, overflow, seq_err;
   logic rd_prev = 1'b0;
   int n_chk = 0, n_fail = 0;
   int n_wr = 0, n_rd = 0, n_start = 0, n_done = 0, n_fd = 0;

   assign uart_done = uart_done_r | uart_stray;

   always #5 clk = ~clk;

   fft_uart_sched #(.FRAME_LEN(FL), .IDX_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .tx_ready(tx_ready),
      .s_valid(s_valid), .s_index(s_index), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .uart_start(uart_start),
      .uart_done(uart_done), .frame_done(frame_done), .overflow(overflow), .seq_err(seq_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // event counters sampled mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (fifo_wr_en) n_wr++;
      if (fifo_rd_en) begin
         check("one_in_flight", n_rd - n_done, 0);
         n_rd++;
      end
      if (uart_start) begin
         check("start_after_rd", rd_prev, 1);
         n_start++;
      end
      if (uart_done_r) n_done++;
      if (frame_done) n_fd++;
      rd_prev = fifo_rd_en;
   end

   // UART model: answers each started word with a done pulse a few cycles later
   initial forever begin
      @(negedge clk);
      if (uart_start && uart_en) begin
         repeat (2) @(posedge clk);
         #1 uart_done_r = 1'b1;
         @(posedge clk);
         #1 uart_done_r = 1'b0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr;
      n_wr = 0; n_rd = 0; n_start = 0; n_done = 0; n_fd = 0;
   endtask

   task automatic request;
      rx_ready = 1'b0;
      repeat (4) tick;
      rx_ready = 1'b1;
      repeat (4) tick;
   endtask

   task automatic stream(input int first, input int n, input int fa, input int fb, input bit jump);
      for (int i = 0; i < n; i++) begin
         s_valid   = 1'b1;
         s_index   = IW'((jump && i >= 4) ? i + 1 : (first + i) % 8);
         fifo_full = (i >= fa && i < fb);
         tick;
      end
      s_valid   = 1'b0;
      fifo_full = 1'b0;
   endtask

   task automatic wait_fd(input int budget);
      int k;
      k = 0;
      while (n_fd == 0 && k < budget) begin
         tick;
         k++;
      end
      check("frame_done_seen", n_fd > 0, 1);
      tick;
   endtask

   task automatic reset_vals(input string tag);
      check({tag, "_tx_ready"}, tx_ready, 1);
      check({tag, "_wr_en"}, fifo_wr_en, 0);
      check({tag, "_rd_en"}, fifo_rd_en, 0);
      check({tag, "_start"}, uart_start, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_seq_err"}, seq_err, 0);
   endtask

   initial begin
      int k;
      repeat (2) tick;
      reset_vals("rst");
      rst_n = 1'b1;
      tick;

      clr; request; stream(0, 10, 0, 0, 0);
      check("t1_tx_low", tx_ready, 0);
      wait_fd(200);
      check("t1_writes", n_wr, 8);
      check("t1_reads", n_rd, 8);
      check("t1_starts", n_start, 8);
      check("t1_dones", n_done, 8);
      check("t1_frame_done", n_fd, 1);
      check("t1_tx_high", tx_ready, 1);
      check("t1_overflow", overflow, 0);
      check("t1_seq_err", seq_err, 0);

      clr; stream(0, 6, 0, 0, 0);
      check("held_high_writes", n_wr, 0);
      check("held_high_tx", tx_ready, 1);

      clr; request; stream(5, 3, 0, 0, 0);
      check("t2_no_early_write", n_wr, 0);
      stream(0, 8, 0, 0, 0);
      check("t2_tx_low", tx_ready, 0);
      wait_fd(200);
      check("t2_writes", n_wr, 8);
      check("t2_frame_done", n_fd, 1);
      check("t2_seq_err", seq_err, 0);

      clr; fifo_empty = 1'b1; request; stream(0, 8, 2, 4, 0);
      check("t3_tx_low", tx_ready, 0);
      check("t3_writes", n_wr, 6);
      check("t3_overflow", overflow, 1);
      repeat (5) tick;
      uart_stray = 1'b1; tick; uart_stray = 1'b0; tick;
      check("t3_empty_no_read", n_rd, 0);
      check("t3_empty_no_start", n_start, 0);
      fifo_empty = 1'b0;
      wait_fd(200);
      check("t3_starts", n_start, 8);
      check("t3_frame_done", n_fd, 1);
      check("t3_overflow_sticky", overflow, 1);

      clr; request;
      check("t4_overflow_cleared", overflow, 0);
      stream(0, 8, 0, 0, 1);
      check("t4_seq_err", seq_err, 1);
      check("t4_writes", n_wr, 8);
      wait_fd(200);
      check("t4_frame_done", n_fd, 1);
      check("t4_starts", n_start, 8);

      clr; request; rx_ready = 1'b0; repeat (4) tick;
      stream(0, 8, 0, 0, 0);
      check("t5_abort_writes", n_wr, 0);
      check("t5_abort_tx", tx_ready, 1);

      clr; request; stream(0, 8, 0, 0, 0);
      rx_ready = 1'b0;
      wait_fd(200);
      check("t6_frame_done", n_fd, 1);
      check("t6_starts", n_start, 8);
      check("t6_tx_high", tx_ready, 1);

      clr; uart_en = 1'b0; request; stream(0, 8, 1, 2, 0);
      k = 0;
      while (n_start == 0 && k < 20) begin
         tick;
         k++;
      end
      check("t7_in_wait", n_start, 1);
      check("t7_overflow_pre", overflow, 1);
      check("t7_tx_low_pre", tx_ready, 0);
      rx_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1 reset_vals("t7");
      tick;
      rst_n = 1'b1; uart_en = 1'b1;
      tick;
      clr; request; stream(0, 8, 0, 0, 0);
      wait_fd(200);
      check("t7_writes", n_wr, 8);
      check("t7_starts", n_start, 8);
      check("t7_frame_done", n_fd, 1);
      check("t7_overflow", overflow, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fft_uart_sched.md
FFT_UART_SCHED -- requirements
Module: fft_uart_sched

Interface
REQ-001 Parameter FRAME_LEN, default 1024, number of FFT output bins per frame to capture and send.
REQ-002 Parameter IDX_W, default 16, width of the FFT output index.
REQ-003 clk  input  1  system clock (100 MHz PLL domain); one clock domain only.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_ready  input  1  host (MCU) request, asynchronous level; high requests one frame.
REQ-006 tx_ready  output  1  host indication; low means frame buffered and transmission starting.
REQ-007 s_valid  input  1  FFT output data valid (m_axis_data_tvalid).
REQ-008 s_index  input  IDX_W  FFT output bin index (m_axis_data_tuser).
REQ-009 fifo_full, fifo_empty  input  1 each  FIFO status flags.
REQ-010 fifo_wr_en  output  1  FIFO write strobe, qualifies the FFT real-part data beat.
REQ-011 fifo_rd_en  output  1  FIFO read strobe; read data is valid one cycle later.
REQ-012 uart_start  output  1  one-cycle pulse; UART latches the FIFO word and sends it.
REQ-013 uart_done  input  1  one-cycle pulse from the UART after the last byte of a word.
REQ-014 frame_done  output  1  one-cycle pulse at the end of a frame.
REQ-015 overflow, seq_err  output  1 each  sticky error flags.

Function
REQ-016 rx_ready SHALL pass through a 2-flop synchronizer; requests SHALL act on the synchronized rising edge only.
REQ-017 States: IDLE, ARM, CAPTURE, HANDOFF, SEND, WAIT_TX, DONE.
REQ-018 IDLE: tx_ready=1; on a synchronized rx_ready rising edge, go to ARM and clear overflow, seq_err and both counters.
REQ-019 ARM: wait for s_valid=1 with s_index=0; that beat SHALL assert fifo_wr_en combinationally in the same cycle, set wr_cnt=1, and go to CAPTURE.
REQ-020 ARM: a synchronized rx_ready low SHALL abort to IDLE; in every other state a low rx_ready is ignored.
REQ-021 CAPTURE: fifo_wr_en = s_valid & ~fifo_full; each s_valid beat increments wr_cnt, whether written or dropped.
REQ-022 CAPTURE: s_valid with fifo_full SHALL drop the beat and set overflow.
REQ-023 CAPTURE: s_valid with s_index != wr_cnt SHALL set seq_err; capture continues without realignment.
REQ-024 CAPTURE: the beat that makes wr_cnt = FRAME_LEN goes to HANDOFF; later s_valid beats are ignored until the next ARM.
REQ-025 HANDOFF: tx_ready goes low (registered) on entry and stays low until IDLE is re-entered; go to SEND the next cycle.
REQ-026 SEND: if fifo_empty=0 and rd_cnt < FRAME_LEN, pulse fifo_rd_en for one cycle.
REQ-027 SEND: uart_start pulses the cycle after fifo_rd_en, rd_cnt increments, and the block goes to WAIT_TX.
REQ-028 SEND: if fifo_empty=1, wait with no read, no error and no timeout.
REQ-029 WAIT_TX: on uart_done, go to SEND if rd_cnt < FRAME_LEN, else go to DONE; at most one word is in flight.
REQ-030 A uart_done outside WAIT_TX SHALL be ignored.
REQ-031 DONE: pulse frame_done for one cycle, then go to IDLE, where tx_ready returns high.
REQ-032 A new request needs a new rx_ready rising edge; a level held high SHALL NOT re-trigger.
REQ-033 Counters are IDX_W+1 bits wide and SHALL NOT wrap within a frame.

Reset
REQ-034 rst_n low at any time, including mid-CAPTURE or mid-SEND, SHALL force IDLE immediately.
REQ-035 Reset values: tx_ready=1; fifo_wr_en, fifo_rd_en, uart_start, frame_done, overflow and seq_err = 0; counters = 0; synchronizer flops = 0.
REQ-036 The block SHALL NOT flush the FIFO on reset; FIFO reset is the system's responsibility.

Verification
REQ-037 FRAME_LEN=8, rx_ready rises, FFT streams index 0..7 continuously -> exactly 8 fifo_wr_en, tx_ready low, 8 rd/start pairs each gated by uart_done, one frame_done, tx_ready high.
REQ-038 Stream starts at index 5 when ARM is entered -> no writes until index 0; the next 8 beats are written.
REQ-039 fifo_full held for 2 beats during CAPTURE -> 6 writes, overflow=1, HANDOFF still reached after 8 beats.
REQ-040 s_index jumps 3->5 -> seq_err=1 and the frame completes normally.
REQ-041 rst_n pulsed low during WAIT_TX -> all outputs return to reset values asynchronously; the next rx_ready edge starts a fresh frame.
REQ-042 rx_ready dropped in ARM -> IDLE with no writes; rx_ready dropped in SEND -> frame completes.
